// File: rtl/retire_commit.sv
// In-order ROB commit: maintains the retirement RAT, releases superseded
// physical registers, and on a mispredicted branch flushes and restores the F-RAT.
module retire_commit #(
  parameter int LOG_ARCH = 5,
  parameter int LOG_PHYS = 6,
  parameter int NUM_ARCH = 32,
  parameter int ENTRY_W  = 104 + LOG_PHYS + LOG_ARCH
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Rob_head_valid,
  input  logic [ENTRY_W-1:0]           Rob_head_entry,
  output logic                         Rob_pop,
  output logic                         Free_reg_valid,
  output logic [LOG_PHYS-1:0]          Free_reg,
  output logic                         Flush,
  output logic                         Redirect_valid,
  output logic [31:0]                  Redirect_PC,
  output logic                         Frat_restore,
  output logic [NUM_ARCH*LOG_PHYS-1:0] Frat_restore_map,
  output logic [31:0]                  Retired_count
);

  localparam int F_PHYS = LOG_ARCH;
  localparam int F_HD   = LOG_ARCH + LOG_PHYS;
  localparam int F_RA   = F_HD + 1;
  localparam int F_ALT  = F_HD + 2;
  localparam int F_PC   = F_ALT + 32;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [NUM_ARCH-1:0][LOG_PHYS-1:0]  rrat_q, rrat_d;
  logic                               free_valid_q, free_valid_d;
  logic [LOG_PHYS-1:0]                free_reg_q, free_reg_d;
  logic                               flush_q, flush_d;
  logic [31:0]                        redirect_pc_q, redirect_pc_d;
  logic [31:0]                        count_q, count_d;

  logic                done;
  logic                req_alt;
  logic                has_dest;
  logic [31:0]         alt_pc;
  logic [LOG_PHYS-1:0] phys;
  logic [LOG_ARCH-1:0] arch;
  logic                commit;
  logic                unused_fields;

  assign done     = Rob_head_entry[ENTRY_W-1];
  assign alt_pc   = Rob_head_entry[F_ALT +: 32];
  assign req_alt  = Rob_head_entry[F_RA];
  assign has_dest = Rob_head_entry[F_HD];
  assign phys     = Rob_head_entry[F_PHYS +: LOG_PHYS];
  assign arch     = Rob_head_entry[0 +: LOG_ARCH];

  // pc, instr and the reserved gap are carried for debug only
  assign unused_fields = ^Rob_head_entry[ENTRY_W-2:F_PC];

  assign commit  = (state_q == RUN) & Rob_head_valid & done;
  assign Rob_pop = commit;

  always_comb begin
    state_d       = state_q;
    rrat_d        = rrat_q;
    free_valid_d  = 1'b0;
    free_reg_d    = free_reg_q;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    count_d       = count_q;
    unique case (state_q)
      RUN: begin
        if (commit) begin
          count_d = count_q + 32'd1;
          if (has_dest) begin
            free_valid_d = 1'b1;
            if (arch != '0) begin
              free_reg_d   = rrat_q[arch];
              rrat_d[arch] = phys;
            end else begin
              free_reg_d = phys;
            end
          end
          if (req_alt) begin
            redirect_pc_d = alt_pc;
            flush_d       = 1'b1;
            state_d       = FLUSH;
          end
        end
      end
      FLUSH: state_d = DRAIN;
      DRAIN: if (!Rob_head_valid) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= RUN;
      for (int i = 0; i < NUM_ARCH; i++)
        rrat_q[i] <= LOG_PHYS'(i);
      free_valid_q  <= 1'b0;
      free_reg_q    <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      rrat_q        <= rrat_d;
      free_valid_q  <= free_valid_d;
      free_reg_q    <= free_reg_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
    end
  end

  assign Free_reg_valid   = free_valid_q;
  assign Free_reg         = free_reg_q;
  assign Flush            = flush_q;
  assign Redirect_valid   = flush_q;
  assign Frat_restore     = flush_q;
  assign Redirect_PC      = redirect_pc_q;
  assign Frat_restore_map = rrat_q;
  assign Retired_count    = count_q;

endmodule

// File: tb/tb_retire_commit.sv
// Randomized scoreboard bench for retire_commit against a
// queue-based commit model.
module tb_retire_commit;

  localparam int LA = 5;
  localparam int LP = 6;
  localparam int NA = 32;
  localparam int EW = 104 + LP + LA;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          Rob_head_valid = 1'b0;
  logic [EW-1:0] Rob_head_entry = '0;
  logic          Rob_pop;
  logic          Free_reg_valid;
  logic [LP-1:0] Free_reg;
  logic          Flush;
  logic          Redirect_valid;
  logic [31:0]   Redirect_PC;
  logic          Frat_restore;
  logic [NA*LP-1:0] Frat_restore_map;
  logic [31:0]   Retired_count;

  retire_commit #(.LOG_ARCH(LA), .LOG_PHYS(LP), .NUM_ARCH(NA)) dut (
    .CLK(CLK), .RESET(RESET),
    .Rob_head_valid(Rob_head_valid), .Rob_head_entry(Rob_head_entry),
    .Rob_pop(Rob_pop),
    .Free_reg_valid(Free_reg_valid), .Free_reg(Free_reg),
    .Flush(Flush), .Redirect_valid(Redirect_valid),
    .Redirect_PC(Redirect_PC), .Frat_restore(Frat_restore),
    .Frat_restore_map(Frat_restore_map), .Retired_count(Retired_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          dly;
    logic [31:0] alt;
    bit          ra;
    bit          hd;
    logic [LP-1:0] ph;
    logic [LA-1:0] ar;
    logic [63:0] junk;
    logic [4:0]  rsv;
  } ent_t;

  int checks = 0;
  int passes = 0;

  ent_t          rob_q[$];
  logic [LP-1:0] free_q[$];
  logic [31:0]   pc_q[$];
  logic [LP-1:0] m_rrat[NA];
  logic [31:0]   m_count;
  int            phase;
  int            clear_in;
  int            clear_force;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
  endtask

  task automatic chk_map(string n);
    logic [NA*LP-1:0] em;
    for (int i = 0; i < NA; i++) em[i*LP +: LP] = m_rrat[i];
    checks++;
    if (Frat_restore_map === em) passes++;
    else $display("FAIL %s: got %h expected %h", n, Frat_restore_map, em);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_rrat[i] = LP'(i);
    m_count  = 0;
    phase    = 0;
    clear_in = 0;
    rob_q.delete();
  endtask

  function automatic logic [EW-1:0] build(ent_t e, bit d);
    logic [EW-1:0] v;
    v = '0;
    v[EW-1]           = d;
    v[EW-2 -: 5]      = e.rsv;
    v[LA+LP+34 +: 64] = e.junk;
    v[LA+LP+2 +: 32]  = e.alt;
    v[LA+LP+1]        = e.ra;
    v[LA+LP]          = e.hd;
    v[LA +: LP]       = e.ph;
    v[0 +: LA]        = e.ar;
    return v;
  endfunction

  function automatic ent_t mk(int dly, bit ra, logic [31:0] alt,
                              bit hd, int ph, int ar);
    ent_t e;
    e.dly  = dly;
    e.ra   = ra;
    e.alt  = alt;
    e.hd   = hd;
    e.ph   = LP'(ph);
    e.ar   = LA'(ar);
    e.junk = {$urandom, $urandom};
    e.rsv  = 5'($urandom);
    return e;
  endfunction

  task automatic commit(ent_t e);
    m_count++;
    if (e.hd) begin
      if (e.ar != 0) begin
        free_q.push_back(m_rrat[e.ar]);
        m_rrat[e.ar] = e.ph;
      end else begin
        free_q.push_back(e.ph);
      end
    end
    if (e.ra) pc_q.push_back(e.alt);
  endtask

  task automatic step();
    bit   v, d, exp_pop;
    ent_t h;
    @(negedge CLK);
    v = rob_q.size() > 0;
    d = 1'b0;
    if (v) begin
      h = rob_q[0];
      d = (h.dly == 0) || (phase != 0);
    end
    Rob_head_valid = v;
    Rob_head_entry = v ? build(h, d) : '0;
    #2;
    exp_pop = (phase == 0) && v && d;
    chk("rob_pop", Rob_pop, exp_pop);
    @(posedge CLK);
    if (clear_in > 0) begin
      clear_in--;
      if (clear_in == 0) rob_q.delete();
    end
    if (exp_pop) begin
      void'(rob_q.pop_front());
      commit(h);
    end else if (v && phase == 0) begin
      rob_q[0].dly--;
    end
    if (exp_pop && h.ra) begin
      phase    = 1;
      clear_in = clear_force > 0 ? clear_force : $urandom_range(1, 4);
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 2 && !v) begin
      phase = 0;
    end
  endtask

  task automatic run_all();
    int n = 0;
    while ((rob_q.size() > 0 || phase != 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    Rob_head_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_pending", free_q.size() + pc_q.size(), 0);
    chk("rst_flush", Flush, 0);
    chk("rst_redir", Redirect_valid, 0);
    chk("rst_frat", Frat_restore, 0);
    chk("rst_free_v", Free_reg_valid, 0);
    chk("rst_free", Free_reg, 0);
    chk("rst_pc", Redirect_PC, 0);
    chk("rst_count", Retired_count, 0);
    chk_map("rst_map");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      if (free_q.size() > 0) begin
        chk("free_valid", Free_reg_valid, 1);
        chk("free_reg", Free_reg, free_q.pop_front());
      end else begin
        chk("free_idle", Free_reg_valid, 0);
      end
      if (pc_q.size() > 0) begin
        chk("flush", Flush, 1);
        chk("redirect_v", Redirect_valid, 1);
        chk("frat_restore", Frat_restore, 1);
        chk("redirect_pc", Redirect_PC, pc_q.pop_front());
      end else begin
        chk("flush_idle", {Flush, Redirect_valid, Frat_restore}, 0);
      end
      chk("retired", Retired_count, m_count);
      chk_map("rrat_map");
    end
  end

  initial begin
    clear_force = 0;
    model_reset();
    #12;
    do_reset();

    rob_q.push_back(mk(0, 0, 0, 1, 40, 3));
    run_all();
    rob_q.push_back(mk(5, 0, 0, 1, 20, 9));
    run_all();
    rob_q.push_back(mk(0, 0, 0, 1, 41, 5));
    rob_q.push_back(mk(0, 0, 0, 1, 42, 5));
    run_all();
    rob_q.push_back(mk(0, 1, 32'h0040_0100, 0, 0, 0));
    rob_q.push_back(mk(0, 0, 0, 1, 11, 12));
    rob_q.push_back(mk(0, 0, 0, 1, 12, 13));
    clear_force = 4;
    run_all();
    clear_force = 0;
    rob_q.push_back(mk(0, 0, 0, 1, 50, 0));
    run_all();

    rob_q.push_back(mk(0, 1, 32'h0000_8000, 1, 33, 7));
    rob_q.push_back(mk(0, 0, 0, 1, 34, 8));
    clear_force = 10;
    for (int i = 0; i < 20 && phase != 2; i++) step();
    step();
    clear_force = 0;
    do_reset();
    repeat (3) step();

    for (int i = 0; i < 300; i++) begin
      rob_q.push_back(mk(($urandom % 4 == 0) ? $urandom_range(1, 3) : 0,
                         ($urandom % 12) == 0, $urandom,
                         ($urandom % 4) != 0, $urandom % 64,
                         ($urandom % 8 == 0) ? 0 : $urandom % 32));
      if ($urandom % 8 == 0) run_all();
    end
    run_all();

    chk("end_free_q", free_q.size(), 0);
    chk("end_pc_q", pc_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
